instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues sequential word fetches to an
//               instruction memory with one-cycle read latency, buffers the
//               returned words in a small in-order FIFO for decode, and
//               handles branch/jump redirects by flushing the buffer and
//               discarding any response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int ADDRESS_BUS_WIDTH = 24,
  parameter int INSTRUCTION_WIDTH = 33,
  parameter int RESET_PC          = 1024,
  parameter int BUF_DEPTH         = 2     // must be at least 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDRESS_BUS_WIDTH-1:0] iram_address,
  input  logic [INSTRUCTION_WIDTH-1:0] iram_data,
  output logic                         iram_read_not_write,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
  output logic                         instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
  input  logic                         instr_ready
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [ADDRESS_BUS_WIDTH-1:0] c_RESET_PC = ADDRESS_BUS_WIDTH'(RESET_PC);
  localparam logic [CNT_W:0]               c_DEPTH    = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]             c_LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  // Control states: RUN = buffer credit available, STALL = occupancy plus
  // inflight request fill the buffer, only a pop can free a slot.
  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_STALL = 1'b1;

  logic [ADDRESS_BUS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_BUS_WIDTH-1:0] r_req_pc;
  logic                         r_inflight;
  logic [0:0]                   r_state;
  logic [CNT_W-1:0]             r_count;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;

  logic [INSTRUCTION_WIDTH-1:0] r_buf_data [BUF_DEPTH];
  logic [ADDRESS_BUS_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_kill;
  logic             w_issue;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W:0]   w_total_next;
  logic [0:0]       w_state_next;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    if (p == c_LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake, kill and issue decisions for the current cycle.
  // Occupancy plus inflight never exceeds BUF_DEPTH, so in STALL exactly one
  // pop is enough to free a slot; in RUN a slot is free already.
  always_comb begin
    w_valid      = (r_count != '0);
    w_pop        = w_valid & instr_ready;
    // A redirect kills the response arriving at this very edge.
    w_kill       = r_inflight & redirect_valid;
    w_push       = r_inflight & ~w_kill;
    w_issue      = ~redirect_valid & ((r_state == c_ST_RUN) | w_pop);
    w_count_next = r_count;
    if (redirect_valid) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    w_total_next = {1'b0, w_count_next} + (CNT_W + 1)'(w_issue);
    w_state_next = (w_total_next >= c_DEPTH) ? c_ST_STALL : c_ST_RUN;
  end

  // Fetch pointer, inflight tracking, FIFO pointers and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= c_RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_state    <= c_ST_RUN;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_count    <= w_count_next;
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + ADDRESS_BUS_WIDTH'(1);
          r_req_pc   <= r_fetch_pc;
        end
        if (w_pop) begin
          r_head <= f_ptr_inc(r_head);
        end
        if (w_push) begin
          r_tail <= f_ptr_inc(r_tail);
        end
      end
    end
  end

  // Buffer storage; contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_tail] <= iram_data;
      r_buf_pc[r_tail]   <= r_req_pc;
    end
  end

  assign iram_address        = r_fetch_pc;
  assign iram_read_not_write = 1'b1;
  assign instr_valid         = w_valid;
  // Gate head outputs so they read zero whenever the buffer is empty,
  // including immediately on reset assertion.
  assign instr_data          = w_valid ? r_buf_data[r_head] : '0;
  assign instr_pc            = w_valid ? r_buf_pc[r_head]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int AW    = 24;
  localparam int IW    = 33;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] iram_address;
  logic [IW-1:0] iram_data;
  logic          iram_read_not_write;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  instr_fetch #(
    .ADDRESS_BUS_WIDTH(AW),
    .INSTRUCTION_WIDTH(IW),
    .RESET_PC(1024),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iram_address(iram_address),
    .iram_data(iram_data),
    .iram_read_not_write(iram_read_not_write),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory contents: four fixed program words, everything else a pc hash.
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    case (a)
      24'd1024: return 33'h011000010;
      24'd1025: return 33'h012000020;
      24'd1026: return 33'h052210000;
      24'd1027: return 33'h030200030;
      default:  return {a[8:0], a} ^ 33'h15A5A5A5A;
    endcase
  endfunction

  // One-cycle synchronous-read instruction memory.
  always @(posedge clk) iram_data <= memf(iram_address);

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] delivered[$];
  logic [AW-1:0] m_fetch;
  logic [AW-1:0] m_req;
  bit            m_infl;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch = 24'd1024;
    m_req   = '0;
    m_infl  = 0;
  endtask

  // Advance the model by one rising edge using the inputs held this cycle.
  task automatic model_edge();
    bit pop, issue;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop   = (q.size() != 0) && instr_ready;
    issue = !redirect_valid && ((q.size() + int'(m_infl) - int'(pop)) < DEPTH);
    if (pop) delivered.push_back(q[0].pc);
    if (redirect_valid) begin
      q.delete();
      m_fetch = redirect_pc;
      m_infl  = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back('{pc: m_req, d: memf(m_req)});
      if (issue) begin
        m_req   = m_fetch;
        m_fetch = m_fetch + 24'd1;
      end
      m_infl = issue;
    end
  endtask

  task automatic compare_all();
    chk("iram_address", iram_address, m_fetch);
    chk("iram_read_not_write", iram_read_not_write, 1);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr_pc", instr_pc, q[0].pc);
      chk("instr_data", instr_data, q[0].d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    model_reset();
    step();
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_iram_address", iram_address, 24'd1024);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    #2;
    chk("rst_instr_valid_async", instr_valid, 0);

    // Sequential fetch with decode always ready.
    do_reset();
    step();
    chk("seq_not_yet_valid", instr_valid, 0);
    step();
    chk("seq_valid0", instr_valid, 1);
    chk("seq_pc0", instr_pc, 24'd1024);
    chk("seq_data0", instr_data, 33'h011000010);
    step();
    chk("seq_pc1", instr_pc, 24'd1025);
    chk("seq_data1", instr_data, 33'h012000020);
    step();
    chk("seq_pc2", instr_pc, 24'd1026);
    chk("seq_data2", instr_data, 33'h052210000);
    step();
    chk("seq_pc3", instr_pc, 24'd1027);
    chk("seq_data3", instr_data, 33'h030200030);

    // Backpressure: address freezes, then everything drains exactly once.
    do_reset();
    step();
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_freeze_addr", iram_address, 24'd1026);
    end
    chk("bp_head", instr_pc, 24'd1024);
    instr_ready = 1'b1;
    delivered.delete();
    for (int i = 0; i < 5; i++) step();
    chk("bp_delivered_cnt_ge4", delivered.size() >= 4, 1);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      chk("bp_delivered_pc", delivered[i], 24'd1024 + i);

    // Redirect while 1024 is at the head and 1025 is inflight, no pop.
    do_reset();
    step();
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 24'd1026;
    step();
    chk("rd_addr_after_e0", iram_address, 24'd1026);
    chk("rd_flushed", instr_valid, 0);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    delivered.delete();
    step();
    chk("rd_e1_not_valid", instr_valid, 0);
    step();
    chk("rd_e2_valid", instr_valid, 1);
    chk("rd_e2_pc", instr_pc, 24'd1026);
    step();
    chk("rd_first_delivered", delivered.size() > 0 ? delivered[0] : 24'hDEAD, 24'd1026);

    // Redirect coinciding with the pop of 1024.
    do_reset();
    step();
    step();
    delivered.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 24'd2000;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("rdpop_pc", instr_pc, 24'd2000);
    step();
    chk("rdpop_cnt", delivered.size(), 2);
    chk("rdpop_d0", delivered.size() > 0 ? delivered[0] : 24'hDEAD, 24'd1024);
    chk("rdpop_d1", delivered.size() > 1 ? delivered[1] : 24'hDEAD, 24'd2000);

    // Address wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 24'hFFFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("wrap_pc0", instr_pc, 24'hFFFFFF);
    step();
    chk("wrap_pc1", instr_pc, 24'h000000);
    chk("wrap_valid1", instr_valid, 1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_drop", instr_valid, 0);
    chk("arst_addr", iram_address, 24'd1024);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("arst_refetch_pc", instr_pc, 24'd1024);
    chk("arst_refetch_data", instr_data, 33'h011000010);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 24'd1026;
        1:       redirect_pc = 24'hFFFFFE + 24'($urandom_range(0, 1));
        default: redirect_pc = 24'($urandom);
      endcase
      if (c == 1200 || c == 2400) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rnd_arst_valid_drop", instr_valid, 0);
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
      chk("rnd_occupancy_bound", q.size() <= DEPTH, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
